// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_pkg
// Purpose  : Shared opcode constants, decoded-op record and decode helpers
//            for the dual-issue dispatch queue.
// Contents : OP_LOAD/OP_STORE/OP_BRANCH, dec_t, decode(), is_mem_op(),
//            raw_hazard()
// Revision : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       is_mem;
        logic       writes_rd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.is_mem    = (instr[6:0] == OP_LOAD) || (instr[6:0] == OP_STORE);
        d.writes_rd = (instr[6:0] != OP_STORE) && (instr[6:0] != OP_BRANCH) &&
                      (instr[11:7] != 5'd0);
        d.rd        = instr[11:7];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        return d;
    endfunction

    function automatic logic is_mem_op(input dec_t d);
        return d.is_mem;
    endfunction

    // Younger op reads a register the older op writes. The rs2 field is
    // compared even for formats where it holds immediate bits; that only
    // errs toward splitting the pair, never toward a wrong dual issue.
    function automatic logic raw_hazard(input dec_t older, input dec_t younger);
        return older.writes_rd &&
               ((younger.rs1 == older.rd) || (younger.rs2 == older.rd));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_fifo
// Purpose  : DEPTH-entry circular buffer; pops 0..2 from the head and pushes
//            0..2 at the tail each cycle, exposes head and head+1.
// Ports    : clk, rstn_i (async active-low), clear_i (sync drop-all),
//            pop_cnt_i, push_cnt_i, push0_i/push1_i (program order),
//            head0_o/head1_o (peek), count_o (occupancy)
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   clear_i,
    input  logic [1:0]             pop_cnt_i,
    input  logic [1:0]             push_cnt_i,
    input  logic [WIDTH-1:0]       push0_i,
    input  logic [WIDTH-1:0]       push1_i,
    output logic [WIDTH-1:0]       head0_o,
    output logic [WIDTH-1:0]       head1_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_tail1;
    logic [PW-1:0]    w_head1;

    // DEPTH is a power of two, so plain pointer overflow gives the wrap.
    assign w_tail1 = r_tail + PW'(1);
    assign w_head1 = r_head + PW'(1);

    always_ff @(posedge clk) begin
        if (!clear_i) begin
            if (push_cnt_i != 2'd0) begin
                r_mem[r_tail] <= push0_i;
            end
            if (push_cnt_i == 2'd2) begin
                r_mem[w_tail1] <= push1_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(pop_cnt_i);
            r_tail  <= r_tail + PW'(push_cnt_i);
            r_count <= r_count - CW'(pop_cnt_i) + CW'(push_cnt_i);
        end
    end

    assign head0_o = r_mem[r_head];
    assign head1_o = r_mem[w_head1];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/dual_issue_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_dispatch_queue
// Purpose  : Dual-issue dispatcher. Picks up to two ops per cycle from the
//            oldest two of {queue head, head+1, fetched pair}; slot 0 owns
//            the memory port, slot 1 is ALU-only. Unissued ops wait in an
//            in-order pending queue.
// Ports    : clk, rstn_i (async active-low)
//            instr1_i/valid1_i, instr2_i/valid2_i, fetch_ready_o  (fetch)
//            issue_ready_i, flush_i                              (control)
//            slot0_instr_o/valid_o, slot1_instr_o/valid_o,
//            order_change_o, split_o, q_count_o                  (issue)
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int ILEN         = 32,
    parameter int DEPTH        = 4,
    parameter int HAZARD_CHECK = 1
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic [ILEN-1:0]        instr1_i,
    input  logic [ILEN-1:0]        instr2_i,
    input  logic                   valid1_i,
    input  logic                   valid2_i,
    output logic                   fetch_ready_o,
    input  logic                   issue_ready_i,
    input  logic                   flush_i,
    output logic [ILEN-1:0]        slot0_instr_o,
    output logic                   slot0_valid_o,
    output logic [ILEN-1:0]        slot1_instr_o,
    output logic                   slot1_valid_o,
    output logic                   order_change_o,
    output logic                   split_o,
    output logic [$clog2(DEPTH):0] q_count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   w_count;
    logic [ILEN-1:0] w_q0;
    logic [ILEN-1:0] w_q1;
    logic            w_accept;
    logic [1:0]      w_in_cnt;

    logic [ILEN-1:0] w_a;
    logic [ILEN-1:0] w_b;
    logic            w_a_valid;
    logic            w_b_valid;
    logic            w_mem_a;
    logic            w_mem_b;
    logic            w_raw;

    logic [1:0]      w_n_issue;
    logic [1:0]      w_pop;
    logic [1:0]      w_in_iss;
    logic [1:0]      w_push_cnt;
    logic [ILEN-1:0] w_push0;

    // Readiness depends on occupancy only, so fetch never sees a
    // combinational path from its own valids.
    assign fetch_ready_o = (CW'(DEPTH) - w_count) >= CW'(2);
    assign w_accept      = valid1_i & fetch_ready_o;
    assign w_in_cnt      = w_accept ? (valid2_i ? 2'd2 : 2'd1) : 2'd0;
    assign q_count_o     = w_count;

    // Window: two oldest valid ops, queue entries first.
    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_a_valid = 1'b0;
        w_b_valid = 1'b0;
        if (w_count >= CW'(2)) begin
            w_a       = w_q0;
            w_b       = w_q1;
            w_a_valid = 1'b1;
            w_b_valid = 1'b1;
        end else if (w_count == CW'(1)) begin
            w_a       = w_q0;
            w_a_valid = 1'b1;
            w_b       = instr1_i;
            w_b_valid = w_accept;
        end else begin
            w_a       = instr1_i;
            w_a_valid = w_accept;
            w_b       = instr2_i;
            w_b_valid = w_accept & valid2_i;
        end
    end

    assign w_mem_a = is_mem_op(decode(w_a[31:0]));
    assign w_mem_b = is_mem_op(decode(w_b[31:0]));
    assign w_raw   = (HAZARD_CHECK != 0) &&
                     raw_hazard(decode(w_a[31:0]), decode(w_b[31:0]));

    // Issue selection. Issued ops are always a prefix (A, or A then B) of
    // the window, which keeps the queue update a simple pop/push count.
    always_comb begin
        slot0_instr_o  = '0;
        slot0_valid_o  = 1'b0;
        slot1_instr_o  = '0;
        slot1_valid_o  = 1'b0;
        order_change_o = 1'b0;
        split_o        = 1'b0;
        w_n_issue      = 2'd0;
        if (issue_ready_i && !flush_i && w_a_valid) begin
            if (!w_b_valid) begin
                slot0_instr_o = w_a;
                slot0_valid_o = 1'b1;
                w_n_issue     = 2'd1;
            end else if ((w_mem_a && w_mem_b) || w_raw) begin
                split_o   = 1'b1;
                w_n_issue = 2'd1;
                // An ALU op ahead of a dependent mem op goes out on slot 1
                // so the mem port stays free for the waiting consumer.
                if (!w_mem_a && w_mem_b) begin
                    slot1_instr_o = w_a;
                    slot1_valid_o = 1'b1;
                end else begin
                    slot0_instr_o = w_a;
                    slot0_valid_o = 1'b1;
                end
            end else if (!w_mem_a && w_mem_b) begin
                slot0_instr_o  = w_b;
                slot0_valid_o  = 1'b1;
                slot1_instr_o  = w_a;
                slot1_valid_o  = 1'b1;
                order_change_o = 1'b1;
                w_n_issue      = 2'd2;
            end else begin
                slot0_instr_o = w_a;
                slot0_valid_o = 1'b1;
                slot1_instr_o = w_b;
                slot1_valid_o = 1'b1;
                w_n_issue     = 2'd2;
            end
        end
    end

    // Split the issued count between queue entries and incoming ops.
    always_comb begin
        if (w_count >= CW'(2)) begin
            w_pop = w_n_issue;
        end else if (w_count == CW'(1)) begin
            w_pop = (w_n_issue != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            w_pop = 2'd0;
        end
    end

    assign w_in_iss   = w_n_issue - w_pop;
    assign w_push_cnt = w_in_cnt - w_in_iss;
    assign w_push0    = (w_in_iss == 2'd0) ? instr1_i : instr2_i;

    dispatch_fifo #(
        .WIDTH (ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .clear_i    (flush_i),
        .pop_cnt_i  (w_pop),
        .push_cnt_i (w_push_cnt),
        .push0_i    (w_push0),
        .push1_i    (instr2_i),
        .head0_o    (w_q0),
        .head1_o    (w_q1),
        .count_o    (w_count)
    );

endmodule
`default_nettype wire
